mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the register file: consumes the rs/rt read data and executes MULT, MULTU, DIV and DIVU over multiple cycles.
- Owns the architectural HI/LO registers.
- Also services MTHI/MTLO writes. HI/LO outputs feed the MFHI/MFLO writeback path back into the register file.

Parameters:
- WIDTH, 32, operand width; must be even and >= 4; HI/LO are WIDTH bits each.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  launch operation; honoured only in IDLE.
- op  in  2  00=MULT (signed), 01=MULTU, 10=DIV (signed), 11=DIVU.
- rs_data  in  WIDTH  multiplicand / dividend (register file read_data1).
- rt_data  in  WIDTH  multiplier / divisor (register file read_data2).
- mthi  in  1  write mt_data into HI.
- mtlo  in  1  write mt_data into LO.
- mt_data  in  WIDTH  data for MTHI/MTLO.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse: HI/LO hold the new result.
- div_by_zero  out  1  one-cycle pulse with done for DIV/DIVU when rt_data was 0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous, active-low (rst_n).
- Reset (rst_n=0 at a rising edge), regardless of state:
  - state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0.
  - Counter and datapath registers cleared.
  - Reset mid-operation aborts it; no done pulse follows.
- States:
  - IDLE: wait for start.
  - CALC: WIDTH iteration cycles.
  - FIX: sign correction and HI/LO commit.
  - Returns to IDLE.
- IDLE, start=1 at edge E0:
  - Latch op and operand magnitudes: absolute values for signed ops, raw values for unsigned ops.
  - Latch result-sign flags; clear the counter.
  - busy=1 after E0. Later changes to rs_data/rt_data/op are ignored.
- CALC, edges E1..E(WIDTH):
  - Multiply: shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle. Partial remainder is WIDTH+1 bits.
  - Counter increments each cycle; leave CALC when counter = WIDTH-1 at the edge.
- FIX, edge E(WIDTH+1):
  - MULT: negate the 2*WIDTH product if the operand signs differ. HI=upper half, LO=lower half.
  - DIV: quotient negated if the signs differ; remainder negated if the dividend is negative. This gives truncation toward zero, with the remainder sign following the dividend. LO=quotient, HI=remainder.
  - Unsigned ops: no negation.
  - After this edge: done=1, busy=0, state=IDLE.
- Latency: fixed. done is high for the single cycle after edge E(WIDTH+1), i.e. WIDTH+1 edges after the start edge (33 for WIDTH=32). The cycle after that, done=0.
- Divide by zero (divisor latched as 0):
  - Full latency is kept.
  - LO = all ones; HI = original rs_data (unsigned and signed alike).
  - div_by_zero pulses with done.
- Signed overflow, DIV most-negative / -1: LO = most-negative value (0x80000000), HI=0. No flag.
- start while busy (CALC/FIX): ignored; no queueing.
- Back-to-back: start may be asserted in the same cycle that done is high (state is IDLE). It is accepted, and busy rises again after that edge.
- mthi/mtlo:
  - Honoured only in IDLE with start=0; written at the edge.
  - Both high: HI and LO both get mt_data.
  - Ignored while busy, and ignored when start=1 in the same cycle (start wins).
- hi/lo: change only on FIX commit, MTHI/MTLO, or reset. Otherwise hold, including throughout CALC.

Test Plan:
- Reset, then MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> busy high for 33 cycles; done pulses exactly 33 edges after start; HI=0xFFFFFFFE, LO=0x00000001.
- MULT rs=0xFFFFFFFD (-3), rt=0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then a back-to-back MULT 0x00010000*0x00010000, with start in the done cycle -> HI=0x00000001, LO=0x00000000.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=7, rt=2 -> LO=3, HI=1. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU rs=0x00001234, rt=0 -> after 33 edges LO=0xFFFFFFFF, HI=0x00001234; div_by_zero=1 only in the done cycle.
- MTHI 0xA5A5A5A5 in IDLE -> hi=0xA5A5A5A5 next cycle. Then start MULTU, and during CALC drive mthi/mtlo and a second start -> all ignored; hi/lo hold until done; final result is correct.
- Start DIVU, drop rst_n at the 10th CALC cycle -> next edge busy=0, hi=lo=0, no done or div_by_zero pulse. A fresh DIVU 100/7 afterwards -> LO=14, HI=2.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply, restoring divide,
// fixed latency of WIDTH+1 edges from start to the done pulse.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  // Handshake: start is taken only when busy=0 (IDLE); busy stays high until the
  // commit edge, after which done (and div_by_zero) pulse for exactly one cycle.
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [WIDTH-1:0]     rs_raw_q, rs_raw_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 dz_q, dz_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  logic [WIDTH-1:0]     rs_abs, rt_abs, quo_fix, rem_fix;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0]   prod_fix;

  assign rs_abs    = (~op[0] & rs_data[WIDTH-1]) ? (WIDTH'(0) - rs_data) : rs_data;
  assign rt_abs    = (~op[0] & rt_data[WIDTH-1]) ? (WIDTH'(0) - rt_data) : rt_data;
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? opb_q : WIDTH'(0)};
  // Divide keeps remainder in the upper half and dividend/quotient in the lower half.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign prod_fix  = neg_res_q ? ((2*WIDTH)'(0) - acc_q) : acc_q;
  assign quo_fix   = neg_res_q ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
  assign rem_fix   = neg_rem_q ? (WIDTH'(0) - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    rs_raw_d  = rs_raw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CALC;
          cnt_d     = '0;
          is_div_d  = op[1];
          neg_res_d = ~op[0] & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
          neg_rem_d = ~op[0] & rs_data[WIDTH-1];
          dz_d      = op[1] & (rt_data == '0);
          rs_raw_d  = rs_data;
          opb_d     = op[1] ? rt_abs : rs_abs;
          acc_d     = {WIDTH'(0), op[1] ? rs_abs : rt_abs};
        end else begin
          if (mthi) hi_d = mt_data;
          if (mtlo) lo_d = mt_data;
        end
      end
      CALC: begin
        if (is_div_q) begin
          if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else                  acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        dbz_d   = dz_q;
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (dz_q) begin
          hi_d = rs_raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      rs_raw_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      rs_raw_q  <= rs_raw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, results, div-by-zero, MTHI/MTLO,
// ignored inputs while busy, back-to-back start and mid-operation reset.
module tb_mult_div_unit;

  localparam int W = 32;
  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] rs_data = '0, rt_data = '0, mt_data = '0;
  logic         mthi = 1'b0, mtlo = 1'b0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] hold_hi, hold_lo;
  logic         saw_done;

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .mthi(mthi), .mtlo(mtlo), .mt_data(mt_data),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; applies start for one edge, then scrambles operands.
  task automatic start_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    hold_hi = hi;
    hold_lo = lo;
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'($urandom_range(0, 3));
    rs_data = $urandom; rt_data = $urandom;
    check("busy_after_start", W'(busy), W'(1));
    check("state_calc", W'(dbg_state), W'(1));
    check("hi_hold_e0", hi, hold_hi);
  endtask

  // From the negedge after E0: 32 busy cycles, then the done cycle after E33.
  task automatic wait_result(input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                             input logic exp_dz, input logic disturb);
    for (int k = 1; k <= 32; k++) begin
      if (disturb && k == 5) begin
        start = 1'b1; op = OP_DIV; mthi = 1'b1; mtlo = 1'b1; mt_data = 32'hDEAD_BEEF;
      end
      if (disturb && k == 6) begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
      @(negedge clk);
      check("busy_calc", W'(busy), W'(1));
      check("done_early", W'(done), W'(0));
      check("hi_hold", hi, hold_hi);
      check("lo_hold", lo, hold_lo);
    end
    @(negedge clk);
    check("done_pulse", W'(done), W'(1));
    check("busy_done", W'(busy), W'(0));
    check("hi_result", hi, exp_hi);
    check("lo_result", lo, exp_lo);
    check("dbz_flag", W'(div_by_zero), W'(exp_dz));
  endtask

  task automatic after_done();
    @(negedge clk);
    check("done_clear", W'(done), W'(0));
    check("dbz_clear", W'(div_by_zero), W'(0));
  endtask

  initial begin
    // reset
    repeat (3) @(negedge clk);
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_dbz", W'(div_by_zero), W'(0));
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    check("rst_state", W'(dbg_state), W'(0));
    rst_n = 1'b1;
    @(negedge clk);

    start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_result(32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
    after_done();

    start_op(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007);
    wait_result(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
    start_op(OP_MULT, 32'h0001_0000, 32'h0001_0000);
    wait_result(32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0);
    after_done();

    start_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_result(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    start_op(OP_DIVU, 32'd7, 32'd2);
    wait_result(32'd1, 32'd3, 1'b0, 1'b0);
    start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result(32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
    start_op(OP_DIV, 32'h0000_0064, 32'hFFFF_FFF9);
    wait_result(32'h0000_0002, 32'hFFFF_FFF2, 1'b0, 1'b0);
    after_done();

    start_op(OP_DIVU, 32'h0000_1234, 32'h0000_0000);
    wait_result(32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1'b0);
    after_done();

    start_op(OP_DIV, 32'hFFFF_FF00, 32'h0000_0000);
    wait_result(32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1, 1'b0);
    after_done();

    // MTHI then MTLO in IDLE
    mthi = 1'b1; mt_data = 32'hA5A5_A5A5;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_hi", hi, 32'hA5A5_A5A5);
    check("mthi_lo_keep", lo, 32'hFFFF_FFFF);
    mtlo = 1'b1; mt_data = 32'h0F0F_0F0F;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo_lo", lo, 32'h0F0F_0F0F);
    check("mtlo_hi_keep", hi, 32'hA5A5_A5A5);

    // start wins over mthi/mtlo; later writes and starts during CALC ignored
    mthi = 1'b1; mtlo = 1'b1; mt_data = 32'h1111_2222;
    start_op(OP_MULTU, 32'h1234_5678, 32'h0000_0010);
    wait_result(32'h0000_0001, 32'h2345_6780, 1'b0, 1'b1);
    after_done();

    // reset during the 10th CALC cycle
    start_op(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", W'(busy), W'(0));
    check("abort_hi", hi, '0);
    check("abort_lo", lo, '0);
    check("abort_done", W'(done), W'(0));
    check("abort_dbz", W'(div_by_zero), W'(0));
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || div_by_zero || busy) saw_done = 1'b1;
    end
    check("abort_no_pulse", W'(saw_done), W'(0));

    start_op(OP_DIVU, 32'd100, 32'd7);
    wait_result(32'd2, 32'd14, 1'b0, 1'b0);
    after_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
